instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch-side initiator for the instruction memory. It owns the fetch PC and issues word reads to the combinational instruction memory (byte address; the memory indexes addr>>2). Returned words are buffered in a small prefetch FIFO. The FIFO feeds decode through a valid/ready handshake and is flushed on branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits[1:0] must be 0
DEPTH, 4, prefetch FIFO entries; power of two, >=2
CNT_W, 3, width of fifo_count; equals clog2(DEPTH+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  32  byte address to instruction memory
imem_re  output  1  read enable to instruction memory
imem_instr  input  32  instruction word, valid combinationally in the same cycle as imem_addr/imem_re
redirect_valid  input  1  branch/jump taken; flush and restart fetch
redirect_pc  input  32  new fetch byte address
if_valid  output  1  head FIFO entry is valid
if_instr  output  32  head instruction
if_pc  output  32  byte address of head instruction
if_ready  input  1  decode accepts head this cycle
fifo_count  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, if_valid=0, if_instr=0, if_pc=0, imem_re=0, imem_addr=RESET_PC, fifo_count=0.
- pop = if_valid & if_ready. The FIFO has room when count<DEPTH or pop=1 in the same cycle.
- Fetch cycle, when !redirect_valid and the FIFO has room:
  - imem_re=1 and imem_addr=fetch_pc.
  - Push {fetch_pc, imem_instr} at the clock edge.
  - fetch_pc <= fetch_pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- FIFO full with no pop: imem_re=0, imem_addr holds fetch_pc, fetch_pc is held, no push.
- Push latency: an entry pushed at edge N is visible on if_valid/if_instr/if_pc from cycle N+1 when the FIFO was empty before the push.
- Outputs:
  - if_valid = (count!=0).
  - if_instr/if_pc show the head entry, and must be stable while if_valid & !if_ready.
  - When count==0, if_instr/if_pc are driven 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Redirect, when redirect_valid=1 at edge N:
  - All entries are discarded, so count=0 after the edge.
  - Any pop that cycle is ignored and has no effect.
  - imem_re=0 that cycle and no push.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are silently cleared.
  - Cycle N+1 fetches the target. if_valid rises in cycle N+2 with if_pc = target.
  - Back-to-back redirects: the last one wins, and each restarts the 2-cycle latency.
- Reset while fetching or while the FIFO holds entries: all state returns to reset values immediately. The first fetch at RESET_PC occurs in the first cycle after rst deasserts.
- fifo_count equals count at all times. It never exceeds DEPTH and never underflows.
- No combinational path from if_ready to if_valid. The only combinational paths from if_ready go to imem_re/imem_addr, through the room calculation.

Test Plan:
- Reset then free-run, RESET_PC=0, if_ready=1, memory word k = 32'h1000_0000+k -> if_valid rises 1 cycle after the first fetch; if_pc sequence 0,4,8,12,...; if_instr 32'h1000_0000, 32'h1000_0001,...; no gaps; fifo_count holds at 1.
- Backpressure: if_ready=0 for 10 cycles -> 4 fetches (pc 0..12), fifo_count=4, imem_re=0 afterwards, if_pc=0 stable. Then if_ready=1 -> pcs 0,4,8,12,16 delivered in order with no loss or duplication, imem_re reasserts the same cycle.
- Redirect with full FIFO: redirect_valid=1, redirect_pc=32'h0000_0103 -> fifo_count=0 next cycle; imem_addr=32'h0000_0100 with imem_re=1 one cycle later; if_pc=32'h100 valid two cycles after the redirect.
- Redirect concurrent with pop, two consecutive redirect cycles to 0x40 then 0x80 -> the popped entry is not delivered twice; the first delivered if_pc is 32'h80.
- Wrap: redirect_pc=32'hFFFF_FFF8 -> delivered if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset asserted mid-cycle with fifo_count=3 -> if_valid=0, fifo_count=0, imem_re=0 immediately, before the next edge; first post-reset if_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory one word per cycle while the prefetch FIFO has room,
// and hands buffered {pc, instr} pairs to decode over valid/ready.
// A redirect from execute flushes the FIFO and restarts fetch at the target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  output logic             imem_re,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             if_ready,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic pop;
  logic room;
  logic push;

  // if_valid depends only on registered count, so if_ready never reaches it
  assign if_valid   = (count != '0);
  assign if_pc      = if_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign if_instr   = if_valid ? buf_instr[rd_ptr] : 32'h0;
  assign fifo_count = count;
  assign imem_addr  = fetch_pc;
  assign imem_re    = push;

  // Room and fetch decision; a pop in the same cycle frees a slot for the push
  always_comb begin
    pop  = if_valid & if_ready;
    room = (count < DEPTH_C) | pop;
    push = room & ~redirect_valid & ~rst;
  end

  // Fetch PC, pointers and occupancy; a redirect overrides any pop or push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= imem_instr;
    end
  end

endmodule
